int_to_float_sched: RTL

//  Shares one pipelined int-to-float converter between N_REQ requesters.

---
 rtl/int_to_float_sched.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/int_to_float_sched.sv
// int_to_float_sched: round-robin front end for one shared int-to-float
// converter, with a result FIFO and a drain FSM.
module int_to_float_sched #(
  parameter int N_REQ      = 4,
  parameter int TAG_W      = 2,
  parameter int CONV_LAT   = 7,
  parameter int HOLD       = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          conv_a,
  input  logic [31:0]          conv_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [TAG_W-1:0]     rsp_tag,
  input  logic                 drain_req,
  output logic                 drain_done,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  // One extra stage so the tag meets conv_z on the
  // edge after the converter output settles.
  localparam int DL = CONV_LAT + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e                      state_q, state_d;
  logic [TAG_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]               hold_q, hold_d;
  logic [31:0]                 conv_a_q, conv_a_d;
  logic [DL-1:0]               dl_vld_q, dl_vld_d;
  logic [DL-1:0][TAG_W-1:0]    dl_tag_q, dl_tag_d;
  logic [31:0]                 mem_q [FIFO_DEPTH];
  logic [31:0]                 mem_d [FIFO_DEPTH];
  logic [TAG_W-1:0]            tmem_q [FIFO_DEPTH];
  logic [TAG_W-1:0]            tmem_d [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               fcnt_q, fcnt_d;
  logic [CW-1:0]               infl_q, infl_d;
  logic                        drain_done_q, drain_done_d;

  logic                        grant_found;
  logic [TAG_W-1:0]            grant_idx;
  logic [SW-1:0]               credit_used;
  logic                        issue_slot;
  logic                        accept;
  logic                        push;
  logic                        pop;
  logic                        quiet;

  // Round-robin search starting at rr_ptr, wrapping.
  always_comb begin : arb_comb
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_W'(idx);
      end
    end
  end

  assign credit_used = SW'(fcnt_q) + SW'(infl_q);
  assign issue_slot  = (hold_q == '0)
                    && (state_q != DRAIN)
                    && (credit_used < SW'(FIFO_DEPTH));
  assign accept      = issue_slot && grant_found;
  assign push        = dl_vld_q[DL-1];
  assign rsp_valid   = (fcnt_q != '0);
  assign pop         = rsp_valid && rsp_ready;
  assign quiet       = (infl_q == '0) && (fcnt_q == '0);

  // One-hot grant, only inside an issue slot.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Operand register, RR pointer and hold counter.
  always_comb begin
    conv_a_d = conv_a_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    if (hold_q != '0) hold_d = hold_q - 1'b1;
    if (accept) begin
      conv_a_d = req_data[32*grant_idx +: 32];
      hold_d   = HW'(HOLD - 1);
      if (grant_idx == TAG_W'(N_REQ - 1))
        rr_ptr_d = '0;
      else
        rr_ptr_d = grant_idx + 1'b1;
    end
  end

  // Valid/tag delay line shadowing the converter.
  always_comb begin
    dl_vld_d = {dl_vld_q[DL-2:0], accept};
    dl_tag_d = {dl_tag_q[DL-2:0], grant_idx};
  end

  // Result FIFO write/read and occupancy.
  always_comb begin
    mem_d    = mem_q;
    tmem_d   = tmem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push) begin
      mem_d[wr_ptr_q]  = conv_z;
      tmem_d[wr_ptr_q] = dl_tag_q[DL-1];
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Work issued to the converter but not yet in the FIFO.
  always_comb begin
    unique case ({accept, push})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase
  end

  // Drain FSM next state and completion pulse.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (drain_req)       state_d = DRAIN;
        else if (|req_valid) state_d = RUN;
      end
      RUN: begin
        if (drain_req)
          state_d = DRAIN;
        else if (!(|req_valid) && quiet)
          state_d = IDLE;
      end
      DRAIN: begin
        if (quiet) begin
          state_d      = IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      hold_q       <= '0;
      conv_a_q     <= '0;
      dl_vld_q     <= '0;
      dl_tag_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcnt_q       <= '0;
      infl_q       <= '0;
      drain_done_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i]  <= '0;
        tmem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_q       <= hold_d;
      conv_a_q     <= conv_a_d;
      dl_vld_q     <= dl_vld_d;
      dl_tag_q     <= dl_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fcnt_q       <= fcnt_d;
      infl_q       <= infl_d;
      drain_done_q <= drain_done_d;
      mem_q        <= mem_d;
      tmem_q       <= tmem_d;
    end
  end

  assign conv_a     = conv_a_q;
  assign rsp_data   = mem_q[rd_ptr_q];
  assign rsp_tag    = tmem_q[rd_ptr_q];
  assign drain_done = drain_done_q;
  assign busy       = !quiet;

endmodule
